// File: rtl/bomb_pkg.sv
// Shared definitions for the defuse controller.
// Holds the controller state enumeration, the key-index width, the default
// defuse code and a helper that extracts one 2-bit digit from a packed code.
package bomb_pkg;

  localparam int unsigned KEY_IDX_W    = 2;
  localparam int unsigned NUM_KEYS     = 4;
  localparam logic [15:0] DEFAULT_CODE = 16'h00E4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_PENALTY,
    ST_WON,
    ST_LOST
  } state_e;

  // Digit idx lives in bits [2*idx+1 : 2*idx]; the shift amount is built by
  // appending a zero bit, so no multiplier is inferred.
  function automatic logic [KEY_IDX_W-1:0] code_digit(input logic [15:0] code,
                                                      input logic [3:0]  idx);
    logic [15:0] shifted;
    shifted = code >> {idx, 1'b0};
    return shifted[KEY_IDX_W-1:0];
  endfunction

endpackage

// File: rtl/defuse_controller_if.sv
// Bundle of the controller's game-side signals.
//   master : drives start, key_in, tick_1s, time_over; observes status.
//   slave  : the defuse controller itself.
// Status: game_won, exploded, locked (registered decodes), progress, strikes.
interface defuse_controller_if;
  logic       start;
  logic [3:0] key_in;
  logic       tick_1s;
  logic       time_over;
  logic       game_won;
  logic       exploded;
  logic [3:0] progress;
  logic [1:0] strikes;
  logic       locked;

  modport master (
    output start, key_in, tick_1s, time_over,
    input  game_won, exploded, progress, strikes, locked
  );

  modport slave (
    input  start, key_in, tick_1s, time_over,
    output game_won, exploded, progress, strikes, locked
  );
endinterface

// File: rtl/defuse_controller_key_edge_detect.sv
// key_edge_detect: per-bit 2-flop synchronizer followed by a rising-edge
// pulse generator.
//   clk, reset : system clock, synchronous active-high reset
//   key_in     : raw asynchronous button levels
//   press      : one-cycle pulse per synchronized 0->1 transition
// A press is reported in the cycle after the synchronized level rises, so the
// consumer acts on the 3rd rising edge after the key is first sampled high.
module key_edge_detect #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] key_in,
  output logic [WIDTH-1:0] press
);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] prev_q,  prev_d;
  logic [WIDTH-1:0] armed_q, armed_d;
  logic [1:0]       fill_q,  fill_d;

  // After reset the chain holds zeros rather than real samples, so a key held
  // through reset would look like a fresh rise. fill_q tracks when sync2_q
  // carries a genuine sample; a bit only arms once that sample shows released.
  always_comb begin
    sync1_d = key_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    fill_d  = {fill_q[0], 1'b1};
    armed_d = armed_q | ({WIDTH{fill_q[1]}} & ~sync2_q);
    press   = sync2_q & ~prev_q & armed_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      armed_q <= '0;
      fill_q  <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      armed_q <= armed_d;
      fill_q  <= fill_d;
    end
  end

endmodule

// File: rtl/defuse_controller.sv
// defuse_controller: bomb-defusal game FSM.
//   clk, reset : 50 MHz system clock, synchronous active-high reset
//   bus        : slave side of defuse_controller_if
//                start     - arms the controller from IDLE
//                key_in    - raw button levels (asynchronous)
//                tick_1s   - one-cycle pulse per second
//                time_over - countdown reached 0:00
//                game_won / exploded / locked - registered state decodes
//                progress  - correct digits entered so far
//                strikes   - wrong entries so far
module defuse_controller
  import bomb_pkg::*;
#(
  parameter int unsigned CODE_LEN    = 4,
  parameter logic [15:0] CODE        = DEFAULT_CODE,
  parameter int unsigned MAX_STRIKES = 3,
  parameter int unsigned PENALTY_S   = 2
) (
  input logic                 clk,
  input logic                 reset,
  defuse_controller_if.slave  bus
);

  localparam logic [3:0] LAST_IDX   = 4'(CODE_LEN - 1);
  localparam logic [1:0] LAST_STRK  = 2'(MAX_STRIKES - 1);
  localparam logic [2:0] LOCK_LOAD  = 3'(PENALTY_S);

  state_e                 state_q, state_d;
  logic [3:0]             progress_q, progress_d;
  logic [1:0]             strikes_q, strikes_d;
  logic [2:0]             lock_cnt_q, lock_cnt_d;
  logic                   game_won_q, game_won_d;
  logic                   exploded_q, exploded_d;
  logic                   locked_q, locked_d;

  logic [NUM_KEYS-1:0]    press;
  logic [KEY_IDX_W-1:0]   key_idx;
  logic                   correct;

  key_edge_detect #(
    .WIDTH (NUM_KEYS)
  ) u_key_edge (
    .clk    (clk),
    .reset  (reset),
    .key_in (bus.key_in),
    .press  (press)
  );

  always_comb begin
    key_idx = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (press[i]) key_idx = KEY_IDX_W'(i);
    end
    // Simultaneous presses never count as correct, whatever the digit.
    correct = $onehot(press) && (key_idx == code_digit(CODE, progress_q));
  end

  always_comb begin
    state_d    = state_q;
    progress_d = progress_q;
    strikes_d  = strikes_q;
    lock_cnt_d = lock_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d    = ST_ARMED;
          progress_d = '0;
          strikes_d  = '0;
        end
      end

      ST_ARMED: begin
        if (bus.time_over) begin
          state_d = ST_LOST;
        end else if (|press) begin
          if (correct) begin
            progress_d = progress_q + 4'd1;
            if (progress_q == LAST_IDX) state_d = ST_WON;
          end else begin
            progress_d = '0;
            // The losing strike is not displayed; strikes holds its last value.
            if (strikes_q == LAST_STRK) begin
              state_d = ST_LOST;
            end else begin
              strikes_d  = strikes_q + 2'd1;
              lock_cnt_d = LOCK_LOAD;
              state_d    = ST_PENALTY;
            end
          end
        end
      end

      ST_PENALTY: begin
        if (bus.time_over) begin
          state_d = ST_LOST;
        end else if (bus.tick_1s) begin
          lock_cnt_d = lock_cnt_q - 3'd1;
          if (lock_cnt_q == 3'd1) state_d = ST_ARMED;
        end
      end

      ST_WON, ST_LOST: begin
        state_d = state_q;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    game_won_d = (state_d == ST_WON);
    exploded_d = (state_d == ST_LOST);
    locked_d   = (state_d == ST_PENALTY);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      progress_q <= '0;
      strikes_q  <= '0;
      lock_cnt_q <= '0;
      game_won_q <= 1'b0;
      exploded_q <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      progress_q <= progress_d;
      strikes_q  <= strikes_d;
      lock_cnt_q <= lock_cnt_d;
      game_won_q <= game_won_d;
      exploded_q <= exploded_d;
      locked_q   <= locked_d;
    end
  end

  assign bus.game_won = game_won_q;
  assign bus.exploded = exploded_q;
  assign bus.locked   = locked_q;
  assign bus.progress = progress_q;
  assign bus.strikes  = strikes_q;

endmodule

// File: tb/tb_defuse_controller.sv
// Self-checking bench for defuse_controller: directed scenarios plus a
// randomized run, all compared against a behavioural game model.
module tb_defuse_controller;

  localparam int unsigned TB_CODE_LEN    = 4;
  localparam logic [15:0] TB_CODE        = 16'h00E4;
  localparam int unsigned TB_MAX_STRIKES = 3;
  localparam int unsigned TB_PENALTY_S   = 2;

  logic clk;
  logic reset;

  defuse_controller_if bus_if ();

  defuse_controller #(
    .CODE_LEN    (TB_CODE_LEN),
    .CODE        (TB_CODE),
    .MAX_STRIKES (TB_MAX_STRIKES),
    .PENALTY_S   (TB_PENALTY_S)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks;
  int unsigned errors;

  // Behavioural model: game described as flags and counters, key presses
  // derived from the per-edge history of sampled key levels.
  bit [3:0] khist[$];
  bit       m_started, m_won, m_lost;
  int       m_lock, m_prog, m_strk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int digit_of(input int idx);
    return int'((TB_CODE >> (2 * idx)) & 16'h3);
  endfunction

  task automatic model_step(input bit rst, input bit st, input bit [3:0] k,
                            input bit tk, input bit to);
    bit [3:0] pr;
    int sz;
    int key;
    if (rst) begin
      khist.delete();
      m_started = 0; m_won = 0; m_lost = 0;
      m_lock = 0; m_prog = 0; m_strk = 0;
      return;
    end
    // A press acts two edges after the key is first sampled high, and only
    // if a low sample since reset precedes it.
    pr = '0;
    sz = khist.size();
    if (sz >= 3) pr = khist[sz-2] & ~khist[sz-3];
    khist.push_back(k);

    if (m_won || m_lost) return;
    if (!m_started) begin
      if (st) begin
        m_started = 1; m_prog = 0; m_strk = 0;
      end
      return;
    end
    if (to) begin
      m_lost = 1;
      return;
    end
    if (m_lock > 0) begin
      if (tk) m_lock--;
      return;
    end
    if (pr != 0) begin
      key = -1;
      for (int i = 0; i < 4; i++) if (pr[i]) key = i;
      if ($countones(pr) == 1 && key == digit_of(m_prog)) begin
        m_prog++;
        if (m_prog == TB_CODE_LEN) m_won = 1;
      end else begin
        m_prog = 0;
        if (m_strk + 1 == TB_MAX_STRIKES) m_lost = 1;
        else begin
          m_strk++;
          m_lock = TB_PENALTY_S;
        end
      end
    end
  endtask

  task automatic cyc(input bit rst, input bit st, input bit [3:0] k,
                     input bit tk, input bit to);
    reset            = rst;
    bus_if.start     = st;
    bus_if.key_in    = k;
    bus_if.tick_1s   = tk;
    bus_if.time_over = to;
    @(posedge clk);
    model_step(rst, st, k, tk, to);
    #1;
    check("game_won", 32'(bus_if.game_won), 32'(m_won));
    check("exploded", 32'(bus_if.exploded), 32'(m_lost));
    check("locked",   32'(bus_if.locked),   32'(m_lock > 0 && !m_lost && !m_won));
    check("progress", 32'(bus_if.progress), 32'(m_prog));
    check("strikes",  32'(bus_if.strikes),  32'(m_strk));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 4'h0, 0, 0);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) cyc(1, 0, 4'h0, 0, 0);
  endtask

  task automatic press_key(input bit [3:0] k, input int hold, input int gap);
    for (int i = 0; i < hold; i++) cyc(0, 0, k, 0, 0);
    idle(gap);
  endtask

  task automatic tick();
    cyc(0, 0, 4'h0, 1, 0);
    idle(2);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus_if.start = 1'b0; bus_if.key_in = '0;
    bus_if.tick_1s = 1'b0; bus_if.time_over = 1'b0;

    // Full correct sequence.
    do_reset();
    idle(2);
    cyc(0, 1, 4'h0, 0, 0);
    press_key(4'h1, 10, 3);
    press_key(4'h2, 10, 3);
    press_key(4'h4, 10, 3);
    press_key(4'h8, 10, 3);
    check("won_after_code", 32'(bus_if.game_won), 32'd1);
    cyc(0, 1, 4'h1, 1, 1);
    idle(4);

    // Wrong entry, presses during lockout, lockout served.
    do_reset();
    cyc(0, 1, 4'h0, 0, 0);
    press_key(4'h1, 4, 2);
    press_key(4'h4, 4, 2);
    check("locked_after_wrong", 32'(bus_if.locked), 32'd1);
    press_key(4'h1, 4, 2);
    press_key(4'h2, 3, 2);
    tick();
    tick();
    check("unlocked_after_ticks", 32'(bus_if.locked), 32'd0);
    press_key(4'h1, 4, 2);

    // Three wrong entries.
    do_reset();
    cyc(0, 1, 4'h0, 0, 0);
    press_key(4'h2, 4, 2); tick(); tick();
    press_key(4'h4, 4, 2); tick(); tick();
    press_key(4'h8, 4, 2);
    check("exploded_third", 32'(bus_if.exploded), 32'd1);
    press_key(4'h1, 4, 2);
    cyc(0, 1, 4'h0, 1, 1);
    idle(3);

    // Final digit coincides with time_over.
    do_reset();
    cyc(0, 1, 4'h0, 0, 0);
    press_key(4'h1, 4, 2);
    press_key(4'h2, 4, 2);
    press_key(4'h4, 4, 2);
    cyc(0, 0, 4'h8, 0, 0);
    cyc(0, 0, 4'h8, 0, 0);
    cyc(0, 0, 4'h8, 0, 1);
    check("timeout_beats_win", 32'(bus_if.game_won), 32'd0);
    idle(3);

    // Two keys on the same clock.
    do_reset();
    cyc(0, 1, 4'h0, 0, 0);
    press_key(4'h6, 5, 3);

    // time_over in IDLE is ignored.
    do_reset();
    cyc(0, 0, 4'h0, 0, 1);
    cyc(0, 0, 4'h0, 0, 1);

    // Reset mid-penalty with key0 held through reset release.
    do_reset();
    cyc(0, 1, 4'h0, 0, 0);
    press_key(4'h2, 4, 2);
    for (int i = 0; i < 3; i++) cyc(1, 0, 4'h1, 0, 0);
    cyc(0, 1, 4'h1, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 4'h1, 0, 0);
    check("held_key_no_press", 32'(bus_if.progress), 32'd0);
    idle(3);
    press_key(4'h1, 4, 2);
    check("repress_counts", 32'(bus_if.progress), 32'd1);

    // Randomized games.
    begin
      bit [3:0] cur_k;
      int rem;
      cur_k = '0;
      rem = 0;
      do_reset();
      for (int n = 0; n < 4000; n++) begin
        bit rst, st, tk, to;
        if (rem == 0) begin
          if (cur_k != 0) begin
            cur_k = '0;
            rem = int'($urandom_range(1, 3));
          end else begin
            if ($urandom_range(0, 9) < 6 && m_prog < TB_CODE_LEN)
              cur_k = 4'(1 << digit_of(m_prog));
            else
              cur_k = 4'($urandom_range(0, 15));
            rem = int'($urandom_range(1, 5));
          end
        end
        rem--;
        st = ($urandom_range(0, 4) == 0);
        tk = ($urandom_range(0, 3) == 0);
        to = ($urandom_range(0, 299) == 0);
        if (m_won || m_lost) rst = ($urandom_range(0, 19) == 0);
        else                 rst = ($urandom_range(0, 399) == 0);
        cyc(rst, st, cur_k, tk, to);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/defuse_controller.md
DEFUSE_CONTROLLER -- requirements
Module: defuse_controller

Interface
REQ-001 Parameter: CODE_LEN, 4, number of digits in the defuse code (legal 1..8).
REQ-002 Parameter: CODE, 16'h00E4, secret code; 2 bits per digit, digit 0 in bits [1:0] (default sequence key0,key1,key2,key3).
REQ-003 Parameter: MAX_STRIKES, 3, wrong entries that trigger a loss (legal 1..3).
REQ-004 Parameter: PENALTY_S, 2, lockout length in tick_1s pulses after a wrong entry (legal 1..7).
REQ-005 clk  input  1  system clock, 50 MHz; the only clock.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  level, active-high; arms the controller from IDLE.
REQ-008 key_in  input  4  raw active-high button levels, asynchronous to clk.
REQ-009 tick_1s  input  1  one-clk pulse per second from the 1 Hz divider.
REQ-010 time_over  input  1  level from the countdown; high once the time reaches 0:00.
REQ-011 game_won  output  1  high while in WON; feeds the countdown's game_won input.
REQ-012 exploded  output  1  high while in LOST.
REQ-013 progress  output  4  count of correct digits entered so far (0..CODE_LEN).
REQ-014 strikes  output  2  count of wrong entries so far.
REQ-015 locked  output  1  high while in PENALTY.

Function
REQ-016 States SHALL be IDLE, ARMED, PENALTY, WON and LOST; all transitions occur on clk rising edges.
REQ-017 Each key_in bit SHALL pass through a 2-flop synchronizer; a press is a 0->1 transition of the synchronized bit.
REQ-018 A press SHALL update state/progress/strikes on the 3rd rising edge after key_in is first sampled high; holding a key produces exactly one press.
REQ-019 IDLE: all presses ignored; start=1 -> ARMED, with progress=0 and strikes=0.
REQ-020 ARMED: a single press whose key index equals digit[progress] of CODE -> progress+1; if that makes progress==CODE_LEN -> WON.
REQ-021 ARMED: a press of any other key, or two or more presses detected in the same cycle, is a wrong entry: progress->0 and strikes+1.
REQ-022 On a wrong entry, if strikes+1==MAX_STRIKES -> LOST; otherwise -> PENALTY with the lockout counter loaded to PENALTY_S.
REQ-023 PENALTY: presses are ignored and discarded; each tick_1s decrements the lockout counter; the tick that reaches 0 -> ARMED.
REQ-024 time_over=1 in ARMED or PENALTY -> LOST on the next edge; this has priority over a simultaneous press, including a final correct digit.
REQ-025 time_over in IDLE SHALL be ignored.
REQ-026 WON and LOST are terminal until reset; presses, start and time_over are ignored in both.
REQ-027 progress and strikes SHALL hold their values in WON, LOST and PENALTY (progress reads 0 in PENALTY).
REQ-028 game_won, exploded and locked are registered state decodes with no combinational path from any input.

Reset
REQ-029 With reset=1 at a clk edge: state=IDLE, progress=0, strikes=0, lockout counter=0, game_won=0, exploded=0, locked=0, and all synchronizer/edge flops = 0.
REQ-030 reset SHALL override every other input in every state, including mid-PENALTY and the terminal states.
REQ-031 A key held high through reset release SHALL NOT produce a press until it is released and pressed again.

Structure
REQ-032 Shared package bomb_pkg SHALL hold the state enumeration, the key-index width (2) and the default CODE constant.
REQ-033 A single sub-module key_edge_detect SHALL implement the synchronizer plus rising-edge pulse, 4 bits wide.
REQ-034 CODE digit selection SHALL index CODE by progress; no division or multiplication.

Verification
REQ-035 Defaults, start, then press key0,key1,key2,key3 (each held 10 clks) -> progress 1,2,3,4; game_won=1; strikes=0.
REQ-036 Armed, press key0 then key2 -> progress 0, strikes=1, locked=1; after 2 tick_1s -> locked=0, state ARMED; presses during lockout leave progress=0.
REQ-037 Three wrong entries with the lockouts served -> strikes=3 is not displayed; exploded=1 on the 3rd wrong press (strikes shows 2 held from before... no update past MAX_STRIKES-1).
REQ-038 progress=3, key3 press edge coincides with time_over=1 -> exploded=1, game_won=0.
REQ-039 key1 and key2 pressed on the same clk while ARMED -> strikes=1, progress=0.
REQ-040 reset asserted in PENALTY with key0 held high -> IDLE with all outputs 0; after start no press is registered until key0 is released and re-pressed.
